// File: rtl/bank_byte_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bank_byte_sequencer
//  Description : Serialises one 32-bit bank word into a 1..4 byte stream over
//                a valid/ready byte interface. The byte select starts at a
//                given index and steps with 2-bit wrap-around. The current
//                select is exported so an external 4:1 mux on the same bank
//                word can follow in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module bank_byte_sequencer #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] word_i,
    input  logic [1:0]  start_i,
    input  logic [1:0]  len_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic        abort_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        byte_last_o,
    output logic [1:0]  sel_o,
    output logic        busy_o
);

    localparam logic [0:0] c_state_idle = 1'b0;
    localparam logic [0:0] c_state_send = 1'b1;

    // Select step: +1 for little-endian order, -1 (mod 4) for big-endian order
    localparam logic [1:0] c_sel_step = BIG_ENDIAN ? 2'b11 : 2'b01;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [31:0] r_word;
    logic [1:0]  r_sel;
    logic [1:0]  r_rem;

    logic w_accept;
    logic w_abort;
    logic w_xfer;

    // Abort wins over a simultaneous handshake: that byte is not transferred
    assign w_accept = word_valid_i && word_ready_o;
    assign w_abort  = (r_state == c_state_send) && abort_i;
    assign w_xfer   = (r_state == c_state_send) && byte_ready_i && !abort_i;

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= c_state_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_state_idle: begin
                if (w_accept) begin
                    w_state_next = c_state_send;
                end
            end
            c_state_send: begin
                if (w_abort) begin
                    w_state_next = c_state_idle;
                end else if (w_xfer && (r_rem == 2'd0)) begin
                    w_state_next = c_state_idle;
                end
            end
            default: w_state_next = c_state_idle;
        endcase
    end

    // Word capture on accept, then select/remaining-count stepping per transfer
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_word <= 32'd0;
            r_sel  <= 2'd0;
            r_rem  <= 2'd0;
        end else if (w_accept) begin
            r_word <= word_i;
            r_sel  <= start_i;
            r_rem  <= len_i;
        end else if (w_xfer && (r_rem != 2'd0)) begin
            r_rem  <= r_rem - 2'd1;
            r_sel  <= r_sel + c_sel_step;
        end
    end

    // Byte and select come straight from registers, so they hold in IDLE and
    // stay stable under backpressure
    assign byte_o = r_word[{r_sel, 3'b000} +: 8];
    assign sel_o  = r_sel;

    // State-decoded handshake and status outputs
    always_comb begin
        word_ready_o = 1'b0;
        byte_valid_o = 1'b0;
        byte_last_o  = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            c_state_idle: begin
                word_ready_o = !wb_rst_i;
            end
            c_state_send: begin
                byte_valid_o = 1'b1;
                busy_o       = 1'b1;
                byte_last_o  = (r_rem == 2'd0);
            end
            default: begin
                word_ready_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_byte_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bank_byte_sequencer
//  Description : Directed self-checking bench for bank_byte_sequencer. Two
//                instances share stimulus: one little-endian, one big-endian.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_byte_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] word;
    logic [1:0]  start;
    logic [1:0]  len;
    logic        wvalid;
    logic        abort;
    logic        bready;

    logic        le_wready, le_bvalid, le_last, le_busy;
    logic [7:0]  le_byte;
    logic [1:0]  le_sel;
    logic        be_wready, be_bvalid, be_last, be_busy;
    logic [7:0]  be_byte;
    logic [1:0]  be_sel;

    int n_checks = 0;
    int n_fail   = 0;

    bank_byte_sequencer #(.BIG_ENDIAN(1'b0)) dut_le (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .word_i      (word),
        .start_i     (start),
        .len_i       (len),
        .word_valid_i(wvalid),
        .word_ready_o(le_wready),
        .abort_i     (abort),
        .byte_o      (le_byte),
        .byte_valid_o(le_bvalid),
        .byte_ready_i(bready),
        .byte_last_o (le_last),
        .sel_o       (le_sel),
        .busy_o      (le_busy)
    );

    bank_byte_sequencer #(.BIG_ENDIAN(1'b1)) dut_be (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .word_i      (word),
        .start_i     (start),
        .len_i       (len),
        .word_valid_i(wvalid),
        .word_ready_o(be_wready),
        .abort_i     (abort),
        .byte_o      (be_byte),
        .byte_valid_o(be_bvalid),
        .byte_ready_i(bready),
        .byte_last_o (be_last),
        .sel_o       (be_sel),
        .busy_o      (be_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundles: {word_ready, busy, byte_valid, byte_last, sel, byte}
    wire [13:0] le_obs = {le_wready, le_busy, le_bvalid, le_last, le_sel, le_byte};
    wire [13:0] be_obs = {be_wready, be_busy, be_bvalid, be_last, be_sel, be_byte};

    function automatic logic [13:0] pack(input logic wr, input logic bz, input logic v,
                                         input logic l, input logic [1:0] s,
                                         input logic [7:0] b);
        return {wr, bz, v, l, s, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word for exactly one accept edge
    task automatic load(input logic [31:0] w, input logic [1:0] s, input logic [1:0] l);
        word   = w;
        start  = s;
        len    = l;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        word   = 32'hDEADBEEF;
        start  = 2'd0;
        len    = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if (le_obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_le: got %h expected %h", le_obs, 14'd0);
        end
        n_checks++;
        if (be_obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_be: got %h expected %h", be_obs, 14'd0);
        end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd0, 8'h00)) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd0, 8'h00));
        end
    endtask

    task automatic test_le_full();
        logic [31:0] eb;
        logic [7:0]  es;
        eb = 32'hDDCCBBAA;
        es = 8'b11_10_01_00;
        bready = 1'b1;
        load(32'hDDCCBBAA, 2'd0, 2'd3);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (le_obs !== pack(0, 1, 1, i == 3, es[2*i +: 2], eb[8*i +: 8])) begin
                n_fail++;
                $display("FAIL le_full_byte%0d: got %h expected %h", i, le_obs,
                         pack(0, 1, 1, i == 3, es[2*i +: 2], eb[8*i +: 8]));
            end
            step();
        end
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd3, 8'hDD)) begin
            n_fail++;
            $display("FAIL le_full_end: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd3, 8'hDD));
        end
    endtask

    task automatic test_wrap();
        logic [23:0] eb;
        logic [5:0]  es;
        eb = 24'h11_44_33;
        es = 6'b00_11_10;
        bready = 1'b1;
        load(32'h44332211, 2'd2, 2'd2);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (le_obs !== pack(0, 1, 1, i == 2, es[2*i +: 2], eb[8*i +: 8])) begin
                n_fail++;
                $display("FAIL wrap_byte%0d: got %h expected %h", i, le_obs,
                         pack(0, 1, 1, i == 2, es[2*i +: 2], eb[8*i +: 8]));
            end
            step();
        end
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd0, 8'h11)) begin
            n_fail++;
            $display("FAIL wrap_end: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd0, 8'h11));
        end
    endtask

    task automatic test_big_endian();
        logic [31:0] eb;
        logic [7:0]  es;
        eb = 32'h33_44_11_22;
        es = 8'b10_11_00_01;
        bready = 1'b1;
        load(32'h44332211, 2'd1, 2'd3);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (be_obs !== pack(0, 1, 1, i == 3, es[2*i +: 2], eb[8*i +: 8])) begin
                n_fail++;
                $display("FAIL be_byte%0d: got %h expected %h", i, be_obs,
                         pack(0, 1, 1, i == 3, es[2*i +: 2], eb[8*i +: 8]));
            end
            step();
        end
        n_checks++;
        if (be_obs !== pack(1, 0, 0, 0, 2'd2, 8'h33)) begin
            n_fail++;
            $display("FAIL be_end: got %h expected %h", be_obs, pack(1, 0, 0, 0, 2'd2, 8'h33));
        end
    endtask

    task automatic test_backpressure();
        bready = 1'b0;
        load(32'hA5000000, 2'd3, 2'd0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (le_obs !== pack(0, 1, 1, 1, 2'd3, 8'hA5)) begin
                n_fail++;
                $display("FAIL backpressure_cyc%0d: got %h expected %h", i, le_obs,
                         pack(0, 1, 1, 1, 2'd3, 8'hA5));
            end
            bready = (i == 3);
            step();
        end
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd3, 8'hA5)) begin
            n_fail++;
            $display("FAIL backpressure_end: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd3, 8'hA5));
        end
        bready = 1'b1;
    endtask

    task automatic test_abort();
        bready = 1'b1;
        load(32'h44332211, 2'd0, 2'd3);
        n_checks++;
        if (le_obs !== pack(0, 1, 1, 0, 2'd0, 8'h11)) begin
            n_fail++;
            $display("FAIL abort_byte0: got %h expected %h", le_obs, pack(0, 1, 1, 0, 2'd0, 8'h11));
        end
        step();
        n_checks++;
        if (le_obs !== pack(0, 1, 1, 0, 2'd1, 8'h22)) begin
            n_fail++;
            $display("FAIL abort_byte1: got %h expected %h", le_obs, pack(0, 1, 1, 0, 2'd1, 8'h22));
        end
        abort = 1'b1;
        step();
        // Aborted handshake must not advance the select
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd1, 8'h22)) begin
            n_fail++;
            $display("FAIL abort_idle: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd1, 8'h22));
        end
        // Abort held high in IDLE must not block the next accept
        load(32'h0000CC00, 2'd1, 2'd0);
        abort = 1'b0;
        n_checks++;
        if (le_obs !== pack(0, 1, 1, 1, 2'd1, 8'hCC)) begin
            n_fail++;
            $display("FAIL abort_reload: got %h expected %h", le_obs, pack(0, 1, 1, 1, 2'd1, 8'hCC));
        end
        step();
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd1, 8'hCC)) begin
            n_fail++;
            $display("FAIL abort_reload_end: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd1, 8'hCC));
        end
    endtask

    task automatic test_back_to_back();
        bready = 1'b1;
        word   = 32'h000000AB;
        start  = 2'd0;
        len    = 2'd0;
        wvalid = 1'b1;
        step();
        // Inputs change while busy and must be ignored
        word  = 32'h0000CD00;
        start = 2'd1;
        n_checks++;
        if (le_obs !== pack(0, 1, 1, 1, 2'd0, 8'hAB)) begin
            n_fail++;
            $display("FAIL b2b_first: got %h expected %h", le_obs, pack(0, 1, 1, 1, 2'd0, 8'hAB));
        end
        step();
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd0, 8'hAB)) begin
            n_fail++;
            $display("FAIL b2b_gap: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd0, 8'hAB));
        end
        step();
        wvalid = 1'b0;
        n_checks++;
        if (le_obs !== pack(0, 1, 1, 1, 2'd1, 8'hCD)) begin
            n_fail++;
            $display("FAIL b2b_second: got %h expected %h", le_obs, pack(0, 1, 1, 1, 2'd1, 8'hCD));
        end
        step();
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd1, 8'hCD)) begin
            n_fail++;
            $display("FAIL b2b_end: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd1, 8'hCD));
        end
    endtask

    task automatic test_async_reset();
        bready = 1'b1;
        load(32'h44332211, 2'd0, 2'd3);
        n_checks++;
        if (le_obs !== pack(0, 1, 1, 0, 2'd0, 8'h11)) begin
            n_fail++;
            $display("FAIL areset_pre: got %h expected %h", le_obs, pack(0, 1, 1, 0, 2'd0, 8'h11));
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (le_obs !== 14'd0) begin
            n_fail++;
            $display("FAIL areset_le: got %h expected %h", le_obs, 14'd0);
        end
        n_checks++;
        if (be_obs !== 14'd0) begin
            n_fail++;
            $display("FAIL areset_be: got %h expected %h", be_obs, 14'd0);
        end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd0, 8'h00)) begin
            n_fail++;
            $display("FAIL areset_release: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd0, 8'h00));
        end
        load(32'h44332211, 2'd2, 2'd1);
        n_checks++;
        if (le_obs !== pack(0, 1, 1, 0, 2'd2, 8'h33)) begin
            n_fail++;
            $display("FAIL areset_next0: got %h expected %h", le_obs, pack(0, 1, 1, 0, 2'd2, 8'h33));
        end
        step();
        n_checks++;
        if (le_obs !== pack(0, 1, 1, 1, 2'd3, 8'h44)) begin
            n_fail++;
            $display("FAIL areset_next1: got %h expected %h", le_obs, pack(0, 1, 1, 1, 2'd3, 8'h44));
        end
        step();
        n_checks++;
        if (le_obs !== pack(1, 0, 0, 0, 2'd3, 8'h44)) begin
            n_fail++;
            $display("FAIL areset_next_end: got %h expected %h", le_obs, pack(1, 0, 0, 0, 2'd3, 8'h44));
        end
    endtask

    initial begin
        rst    = 1'b1;
        word   = 32'd0;
        start  = 2'd0;
        len    = 2'd0;
        wvalid = 1'b0;
        abort  = 1'b0;
        bready = 1'b1;
        test_reset();
        test_le_full();
        test_wrap();
        test_big_endian();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bank_byte_sequencer.md
Name: bank_byte_sequencer

Overview:
Controller that serialises one 32-bit bank word into a stream of bytes, from 1 to 4 bytes long, over a valid/ready byte interface.
It accepts a word with a start byte index and a length, then steps the byte-select through the word with wrap-around, one byte per accepted transfer.
It exports the current select so an external 4:1 byte mux on the same bank word can be driven in lockstep.
It sits between the bank read path and any byte-wide consumer.

Parameters:
BIG_ENDIAN, 0, step direction: 0 = select increments (0→1→2→3→0), 1 = select decrements (3→2→1→0→3)

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  reset, asynchronous, active-high
word_i  input  32  bank word to serialise
start_i  input  2  index of first byte (0 = word_i[7:0] … 3 = word_i[31:24])
len_i  input  2  number of bytes minus 1 (0 = 1 byte … 3 = 4 bytes)
word_valid_i  input  1  word_i/start_i/len_i valid
word_ready_o  output  1  sequencer can accept a word
abort_i  input  1  synchronous abort of the current word
byte_o  output  8  current byte
byte_valid_o  output  1  byte_o valid
byte_ready_i  input  1  consumer accepts byte_o
byte_last_o  output  1  current byte is the final byte of the word
sel_o  output  2  current byte index (drives external byte mux)
busy_o  output  1  sequencer holds a word

Behaviour:
- Reset (async, active-high): state=IDLE; word_q=0; sel_q=0; rem_q=0. While reset is asserted, all outputs are 0, including word_ready_o.
- States: IDLE, SEND.
- Word accept: word_ready_o = (state==IDLE) && !wb_rst_i. Accept occurs on a clock edge where word_valid_i && word_ready_o. On accept:
  - word_q<=word_i, sel_q<=start_i, rem_q<=len_i.
  - state<=SEND.
- Accept latency: first byte_valid_o is high in the cycle after accept. No byte is presented in the accept cycle.
- Output assignments in SEND:
  - byte_valid_o=1; busy_o=1; sel_o=sel_q.
  - byte_o=word_q[8*sel_q +: 8].
  - byte_last_o=(rem_q==0).
- Output assignments in IDLE: byte_valid_o=0, byte_last_o=0, busy_o=0. byte_o and sel_o hold their last values; consumers must not rely on them.
- Byte transfer: occurs on an edge where byte_valid_o && byte_ready_i.
  - If rem_q==0: state<=IDLE.
  - Else: rem_q<=rem_q-1; sel_q<=sel_q+1 (BIG_ENDIAN=0) or sel_q-1 (BIG_ENDIAN=1), modulo 4 (2-bit wrap, 3→0 or 0→3).
- Backpressure: while byte_valid_o && !byte_ready_i, byte_o, sel_o and byte_last_o are held stable. byte_valid_o is never withdrawn except by abort_i or reset.
- Throughput: a word of N bytes occupies N+1 cycles minimum (1 accept + N transfers). word_ready_o rises in the cycle after the last transfer. There is no same-cycle reload.
- abort_i: sampled only in SEND and has priority over a simultaneous byte transfer. On the edge it is high in SEND, state<=IDLE and the remaining bytes are dropped. A byte handshaking in that same cycle is considered not transferred. abort_i in IDLE has no effect and does not block an accept.
- len_i=3 with any start_i visits all four bytes exactly once.
- Reset asserted mid-word returns the block to IDLE immediately; no further bytes are emitted.
- word_i/start_i/len_i are ignored outside the accept edge. Changes while busy have no effect.

Test Plan:
- Little-endian full word: BIG_ENDIAN=0, word_i=32'hDDCCBBAA, start_i=0, len_i=3, byte_ready_i=1. Required: bytes AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept; sel_o 0,1,2,3; byte_last_o only with DD; word_ready_o high the following cycle.
- Wrap-around: start_i=2, len_i=2, word_i=32'h44332211. Required: bytes 33,44,11 with sel_o 2,3,0; last on 11.
- Big-endian wrap: BIG_ENDIAN=1, start_i=1, len_i=3, word_i=32'h44332211. Required: bytes 22,11,44,33 with sel_o 1,0,3,2.
- Backpressure: single byte (start_i=3, len_i=0, word_i=32'hA5000000), byte_ready_i low 3 cycles then high. Required: byte_o=A5, byte_valid_o=1, byte_last_o=1 held for 4 cycles; transfer on the 4th; word_ready_o low throughout SEND.
- Abort and simultaneous handshake: 4-byte word, abort_i high with byte_ready_i on the 2nd byte. Required: only the 1st byte counts as transferred; IDLE next cycle, busy_o=0, word_ready_o=1; a new word is accepted normally afterwards.
- Async reset mid-word: assert wb_rst_i between edges during SEND. Required: byte_valid_o, busy_o and word_ready_o go 0 immediately without waiting for a clock edge; after release, word_ready_o=1 and the next word starts cleanly from its start_i.
